// File: rtl/kb_scan_ctrl.sv
// Scanned-keypad controller: walks key_addr, debounces one key at a time
// (first key wins) and latches {shift, code} with an irq/overrun handshake.
// Optional 5200-style low-nibble code remap when KB_REMAP_5200_EN is defined.
module kb_scan_ctrl #(
  parameter int ADDR_W    = 6,
  parameter int DEB_SCANS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_tick,
  input  logic              scan_en,
  input  logic              deb_en,
  input  logic              kr1_n,
  input  logic              kr2_n,
  input  logic              irq_ack,
  output logic [ADDR_W-1:0] key_addr,
  output logic [ADDR_W:0]   kbcode,
  output logic              key_down,
  output logic              irq,
  output logic              overrun
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [3:0] DEB_MAX = 4'(DEB_SCANS);

  logic [1:0]        state, state_nxt;
  logic [3:0]        cnt, cnt_nxt, cnt_inc;
  logic [ADDR_W-1:0] cand, cand_nxt;
  logic [3:0]        thr;
  logic              tick, pressed, at_cand;
  logic              latch, release_done;

  // Each 2-bit field of the low nibble is negated modulo 4 for the 5200 layout.
  function automatic logic [ADDR_W-1:0] remap(input logic [ADDR_W-1:0] code);
    logic [ADDR_W-1:0] r;
    r = code;
`ifdef KB_REMAP_5200_EN
    for (int i = 0; i < 2; i++) begin
      r[2*i +: 2] = 2'd0 - code[2*i +: 2];
    end
`endif
    return r;
  endfunction

  assign tick    = scan_tick & scan_en;
  assign thr     = deb_en ? DEB_MAX : 4'd1;
  assign pressed = ~kr1_n;
  assign at_cand = (key_addr == cand);
  assign cnt_inc = cnt + 4'd1;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt    = state;
    cnt_nxt      = cnt;
    cand_nxt     = cand;
    latch        = 1'b0;
    release_done = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (pressed) begin
            cand_nxt = key_addr;
            cnt_nxt  = 4'd1;
            if (4'd1 >= thr) begin
              state_nxt = ST_HELD;
              latch     = 1'b1;
            end else begin
              state_nxt = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (at_cand) begin
            if (pressed) begin
              cnt_nxt = cnt_inc;
              if (cnt_inc >= thr) begin
                state_nxt = ST_HELD;
                latch     = 1'b1;
              end
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        ST_HELD: begin
          if (at_cand && !pressed) begin
            if (thr == 4'd1) begin
              state_nxt    = ST_IDLE;
              release_done = 1'b1;
            end else begin
              cnt_nxt   = 4'd1;
              state_nxt = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (at_cand) begin
            if (pressed) begin
              state_nxt = ST_HELD;
            end else begin
              cnt_nxt = cnt_inc;
              if (cnt_inc >= thr) begin
                state_nxt    = ST_IDLE;
                release_done = 1'b1;
              end
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: state is updated only with non-blocking assignments, and reset is
  // sampled on the clock edge so it overrides scan_tick and irq_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      cand     <= '0;
      key_addr <= '0;
      kbcode   <= '0;
      key_down <= 1'b0;
      irq      <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
      if (tick) begin
        key_addr <= key_addr + ADDR_W'(1);
      end
      if (latch) begin
        kbcode   <= {~kr2_n, remap(cand_nxt)};
        key_down <= 1'b1;
      end else if (release_done) begin
        key_down <= 1'b0;
      end
      // An acknowledge wins over overrun but never over a fresh latch.
      irq     <= latch | (irq & ~irq_ack);
      overrun <= ~irq_ack & (overrun | (latch & irq));
    end
  end

endmodule

// File: doc/kb_scan_ctrl.md
KB_SCAN_CTRL -- requirements
Module: kb_scan_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6: scan address width; keypad has 2^ADDR_W positions; ADDR_W >= 4.
REQ-002 The block SHALL have parameter DEB_SCANS, default 2: consecutive full scans needed to accept a press or a release; range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous to clk and active-high.
REQ-005 The block SHALL have port scan_tick, input, 1 bit: single-cycle strobe that samples the sense lines and advances the scan address.
REQ-006 The block SHALL have port scan_en, input, 1 bit: scanning enabled; when 0, scan_tick is ignored and all state holds.
REQ-007 The block SHALL have port deb_en, input, 1 bit: debounce enable; when 0, the effective DEB_SCANS is 1.
REQ-008 The block SHALL have port kr1_n, input, 1 bit: active-low key sense for the current key_addr.
REQ-009 The block SHALL have port kr2_n, input, 1 bit: active-low secondary (shift/top) button sense.
REQ-010 The block SHALL have port irq_ack, input, 1 bit: single-cycle strobe that clears irq and overrun.
REQ-011 The block SHALL have port key_addr, output, ADDR_W bits: current scan address driven to the keypad.
REQ-012 The block SHALL have port kbcode, output, ADDR_W+1 bits: latched code as {shift, code[ADDR_W-1:0]}.
REQ-013 The block SHALL have port key_down, output, 1 bit: a debounced key is held.
REQ-014 The block SHALL have port irq, output, 1 bit: new kbcode latched and not yet acknowledged.
REQ-015 The block SHALL have port overrun, output, 1 bit: sticky flag for a new code latched while irq was already set.

Function
REQ-016 On each scan_tick with scan_en=1, the block SHALL sample kr1_n/kr2_n against the current key_addr, then increment key_addr, wrapping from 2^ADDR_W-1 to 0.
REQ-017 The block SHALL use states IDLE, CONFIRM, HELD and RELEASE, with counter cnt (4 bits) and candidate address cand.
REQ-018 In IDLE, a sample with kr1_n=0 SHALL set cand to the sampled address and cnt to 1; if cnt >= DEB_SCANS, go to HELD with latch; otherwise go to CONFIRM.
REQ-019 In CONFIRM, only samples at address cand SHALL be considered: on kr1_n=0, increment cnt, and at DEB_SCANS go to HELD with latch; on kr1_n=1, go to IDLE.
REQ-020 Latch SHALL mean: on the cycle after the qualifying tick, kbcode={~kr2_n sampled on that tick, remap(cand)}, key_down=1, irq=1, and overrun=1 if irq was already 1.
REQ-021 In HELD, a sample at cand with kr1_n=1 SHALL set cnt=1 and go to RELEASE, or go directly to IDLE with key_down=0 when the effective DEB_SCANS is 1.
REQ-022 In RELEASE, a sample at cand with kr1_n=0 SHALL return to HELD; with kr1_n=1, increment cnt, and at DEB_SCANS clear key_down and go to IDLE.
REQ-023 Presses at addresses other than cand SHALL be ignored in CONFIRM, HELD and RELEASE; this gives first-key-wins rollover.
REQ-024 irq_ack SHALL clear irq and overrun on the next cycle; when a latch coincides with irq_ack, irq SHALL end at 1 and overrun at 0.
REQ-025 kbcode SHALL hold its value until the next latch; release SHALL NOT alter kbcode.
REQ-026 When deb_en changes mid-sequence, the new threshold SHALL apply at the next comparison.

Reset
REQ-027 While rst=1 at a clk edge, the block SHALL set state to IDLE, key_addr=0, cnt=0, cand=0, kbcode=0, key_down=0, irq=0 and overrun=0.
REQ-028 Reset SHALL take precedence over scan_tick and irq_ack in the same cycle.
REQ-029 Reset during CONFIRM, HELD or RELEASE SHALL discard the sequence, and no irq SHALL result from it.

Configuration
REQ-030 With macro KB_REMAP_5200_EN defined, remap SHALL replace code[3:0] with each 2-bit field negated modulo 4 (e.g. 1->3, 4->C, 5->F, 9->B, F->5, 0->0), leaving code[ADDR_W-1:4] unchanged.
REQ-031 Without KB_REMAP_5200_EN, remap SHALL be identity.

Verification
REQ-032 The bench SHALL cover: DEB_SCANS=2, deb_en=1, kr1_n=0 only at address 5 for two scans, remap on -> kbcode=0x0F one cycle after the second address-5 tick, irq=1, key_down=1.
REQ-033 The bench SHALL cover: a key held at address 5 for one scan only -> no irq, state back to IDLE, kbcode unchanged.
REQ-034 The bench SHALL cover: a key at 0x09 latched with irq unacknowledged, then a key at 0x02 latched -> kbcode=0x02 (remap on), overrun=1; irq_ack -> irq=0, overrun=0.
REQ-035 The bench SHALL cover: keys at 3 and 7 pressed together, 3 first -> kbcode from address 3 only; key_down drops after two scans with 3 released.
REQ-036 The bench SHALL cover: deb_en=0, a key at address 0x2C with kr2_n=0 -> latch after the first tick, kbcode={1,0x24} with remap, {1,0x2C} without.
REQ-037 The bench SHALL cover: rst asserted in CONFIRM, and a latch tick coinciding with irq_ack -> all outputs 0 after reset; irq=1 and overrun=0 for the coincidence case.
